alu_exec_unit: RTL and testbench

//  Multi-cycle KGP-RISC execute-stage ALU. Consumes the 4-bit alu_control_signal from the ALU control unit, plus the operands.
//  - Produces a registered result and the carry/zero/sign flags used by branch logic.
//  - Shifts run iteratively, one bit per cycle. All other ops complete in one cycle.
//  - Input valid/ready handshake; output is a one-cycle valid pulse.

---
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 164 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for alu_exec_unit
interface alu_exec_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          alu_control_signal;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   result;
    logic                out_valid;
    logic                carry_flag;
    logic                zero_flag;
    logic                sign_flag;
    logic                err;

    modport master (
        output in_valid, alu_control_signal, op_a, op_b, shamt,
        input  in_ready, result, out_valid, carry_flag, zero_flag, sign_flag, err
    );

    modport slave (
        input  in_valid, alu_control_signal, op_a, op_b, shamt,
        output in_ready, result, out_valid, carry_flag, zero_flag, sign_flag, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle execute ALU, iterative shifter unless FAST_SHIFT_EN
// FAST_SHIFT_EN: single-cycle barrel shifts, SHIFT state unreachable.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_COMP  = 4'b0001;
    localparam logic [3:0] OP_DIFF  = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SHLL  = 4'b0101;
    localparam logic [3:0] OP_SHRL  = 4'b0110;
    localparam logic [3:0] OP_SHRA  = 4'b0111;
    localparam logic [3:0] OP_SHLLV = 4'b1101;
    localparam logic [3:0] OP_SHRLV = 4'b1110;
    localparam logic [3:0] OP_SHRAV = 4'b1111;

    localparam logic [1:0] K_LEFT   = 2'd0;
    localparam logic [1:0] K_LRIGHT = 2'd1;
    localparam logic [1:0] K_ARIGHT = 2'd2;

`ifdef FAST_SHIFT_EN
    localparam bit ITER_SHIFT = 1'b0;
`else
    localparam bit ITER_SHIFT = 1'b1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [1:0]          kind_q;
    logic                carry_q, zero_q, sign_q, out_valid_q, err_q, in_ready_q;

    logic [DATA_W-1:0]   a, b, res_c, step_d;
    logic [DATA_W:0]     sum;
    logic [SHAMT_W-1:0]  amt;
    logic [1:0]          kind;
    logic                carry_wr, bad, is_shift;

    assign a = bus.op_a;
    assign b = bus.op_b;

    always_comb begin
        sum      = '0;
        res_c    = '0;
        carry_wr = 1'b0;
        bad      = 1'b0;
        is_shift = 1'b0;
        amt      = '0;
        kind     = K_LEFT;
        case (bus.alu_control_signal)
            OP_ADD:   begin sum = {1'b0, a} + {1'b0, b};  carry_wr = 1'b1; end
            OP_COMP:  begin sum = {1'b0, ~b} + (DATA_W+1)'(1); carry_wr = 1'b1; end
            OP_DIFF:  begin sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1); carry_wr = 1'b1; end
            OP_AND:   res_c = a & b;
            OP_XOR:   res_c = a ^ b;
            OP_SHLL:  begin is_shift = 1'b1; amt = bus.shamt; kind = K_LEFT; end
            OP_SHRL:  begin is_shift = 1'b1; amt = bus.shamt; kind = K_LRIGHT; end
            OP_SHRA:  begin is_shift = 1'b1; amt = bus.shamt; kind = K_ARIGHT; end
            OP_SHLLV: begin is_shift = 1'b1; amt = b[SHAMT_W-1:0]; kind = K_LEFT; end
            OP_SHRLV: begin is_shift = 1'b1; amt = b[SHAMT_W-1:0]; kind = K_LRIGHT; end
            OP_SHRAV: begin is_shift = 1'b1; amt = b[SHAMT_W-1:0]; kind = K_ARIGHT; end
            default:  bad = 1'b1;
        endcase
        if (carry_wr) res_c = sum[DATA_W-1:0];
        if (is_shift) begin
`ifdef FAST_SHIFT_EN
            case (kind)
                K_LEFT:   res_c = a << amt;
                K_LRIGHT: res_c = a >> amt;
                default:  res_c = $unsigned($signed(a) >>> amt);
            endcase
`else
            // Only consumed for zero-amount shifts; nonzero amounts iterate.
            res_c = a;
`endif
        end
    end

    always_comb begin
        step_d = shreg_q;
        case (kind_q)
            K_LEFT:   step_d = {shreg_q[DATA_W-2:0], 1'b0};
            K_LRIGHT: step_d = {1'b0, shreg_q[DATA_W-1:1]};
            default:  step_d = {shreg_q[DATA_W-1], shreg_q[DATA_W-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            kind_q      <= K_LEFT;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (bad) begin
                            // Unsupported code leaves every flag untouched.
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (ITER_SHIFT && is_shift && (amt != '0)) begin
                            shreg_q <= a;
                            cnt_q   <= amt;
                            kind_q  <= kind;
                            state_q <= S_SHIFT;
                        end else begin
                            result_q    <= res_c;
                            zero_q      <= (res_c == '0);
                            sign_q      <= res_c[DATA_W-1];
                            if (carry_wr) carry_q <= sum[DATA_W];
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_q <= step_d;
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q    <= step_d;
                        zero_q      <= (step_d == '0);
                        sign_q      <= step_d[DATA_W-1];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.result     = result_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;
    assign bus.sign_flag  = sign_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic int exp_lat(input int n);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n + 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, output int lat);
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL pre_accept_ready got %b exp 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.alu_control_signal = c; bus.op_a = a; bus.op_b = b; bus.shamt = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.op_a = '1; bus.op_b = '1; bus.shamt = '1; bus.alu_control_signal = 4'h3;
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.alu_control_signal = '0;
        bus.op_a = '0; bus.op_b = '0; bus.shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL rst_result got %h exp 0", bus.result); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {bus.carry_flag, bus.zero_flag, bus.sign_flag}); end
        n_cmp++; if ({bus.out_valid, bus.err} !== 2'b00) begin n_err++; $display("FAIL rst_valid_err got %b exp 00", {bus.out_valid, bus.err}); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        int lat;
        run_op(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency got %0d exp 1", lat); end
        n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL add_result got %h exp 0", bus.result); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag, bus.err} !== 4'b1100) begin n_err++; $display("FAIL add_flags cze_err got %b exp 1100", {bus.carry_flag, bus.zero_flag, bus.sign_flag, bus.err}); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse_width got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_shra_midpulse();
        int  lat;
        bit  ready_bad;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control_signal = 4'b0111; bus.op_a = 32'h8000_0000; bus.op_b = 32'h0; bus.shamt = 5'd4;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; ready_bad = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ready_bad = 1'b1;
            if (bus.out_valid === 1'b1) begin lat = k; break; end
            if (k == 2) begin
                bus.in_valid = 1'b1; bus.alu_control_signal = 4'b0000; bus.op_a = 32'h1; bus.op_b = 32'h1;
            end else bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (lat !== exp_lat(4)) begin n_err++; $display("FAIL shra_latency got %0d exp %0d", lat, exp_lat(4)); end
        n_cmp++; if (ready_bad !== 1'b0) begin n_err++; $display("FAIL shra_ready_low got %b exp 0", ready_bad); end
        n_cmp++; if (bus.result !== 32'hF800_0000) begin n_err++; $display("FAIL shra_result got %h exp f8000000", bus.result); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b101) begin n_err++; $display("FAIL shra_flags got %b exp 101", {bus.carry_flag, bus.zero_flag, bus.sign_flag}); end
        lat = 0;
        for (int k = 1; k <= 4; k++) begin @(negedge clk); if (bus.out_valid === 1'b1) lat++; end
        n_cmp++; if (lat !== 0 || bus.result !== 32'hF800_0000) begin n_err++; $display("FAIL shra_ignored_pulse got %0d extra valids result %h exp 0 f8000000", lat, bus.result); end
    endtask

    task automatic test_xor_carry_hold();
        int lat;
        run_op(4'b0000, 32'h7FFF_FFFF, 32'h8000_0001, 5'd0, lat);
        n_cmp++; if (bus.carry_flag !== 1'b1 || bus.result !== 32'h0) begin n_err++; $display("FAIL xor_pre_add got c=%b r=%h exp c=1 r=0", bus.carry_flag, bus.result); end
        run_op(4'b0100, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 5'd0, lat);
        n_cmp++; if (lat !== 1 || bus.result !== 32'h0) begin n_err++; $display("FAIL xor_result got lat=%0d r=%h exp lat=1 r=0", lat, bus.result); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b110) begin n_err++; $display("FAIL xor_flags got %b exp 110", {bus.carry_flag, bus.zero_flag, bus.sign_flag}); end
    endtask

    task automatic test_arith();
        logic [3:0]  code [5] = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0011};
        logic [31:0] va   [5] = '{32'h5, 32'h3, 32'h1234, 32'h1234, 32'hF0F0_F0F0};
        logic [31:0] vb   [5] = '{32'h3, 32'h5, 32'h0, 32'h1, 32'h0FF0_0FF0};
        logic [31:0] vr   [5] = '{32'h2, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h00F0_00F0};
        logic        vc   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(code[i], va[i], vb[i], 5'd0, lat);
            n_cmp++;
            if (lat !== 1 || bus.result !== vr[i] || bus.carry_flag !== vc[i] ||
                bus.zero_flag !== (vr[i] == 32'h0) || bus.sign_flag !== vr[i][31]) begin
                n_err++;
                $display("FAIL arith_%0d got lat=%0d r=%h c=%b z=%b s=%b exp lat=1 r=%h c=%b", i, lat,
                         bus.result, bus.carry_flag, bus.zero_flag, bus.sign_flag, vr[i], vc[i]);
            end
        end
    endtask

    task automatic test_bad_code();
        int lat;
        run_op(4'b0000, 32'hC000_0000, 32'hC000_0000, 5'd0, lat);
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b101) begin n_err++; $display("FAIL bad_pre_flags got %b exp 101", {bus.carry_flag, bus.zero_flag, bus.sign_flag}); end
        run_op(4'b1011, 32'h0, 32'h0, 5'd0, lat);
        n_cmp++; if (lat !== 1 || bus.err !== 1'b1 || bus.result !== 32'h0) begin n_err++; $display("FAIL bad_result got lat=%0d err=%b r=%h exp lat=1 err=1 r=0", lat, bus.err, bus.result); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b101) begin n_err++; $display("FAIL bad_flags_held got %b exp 101", {bus.carry_flag, bus.zero_flag, bus.sign_flag}); end
        @(negedge clk);
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL bad_err_pulse got %b exp 0", bus.err); end
    endtask

    task automatic test_shifts();
        logic [3:0]  code [6] = '{4'b0101, 4'b0110, 4'b1101, 4'b1111, 4'b0111, 4'b1110};
        logic [31:0] va   [6] = '{32'h1, 32'h8000_0000, 32'h3, 32'h7000_000F, 32'h8000_000F, 32'h8000_000F};
        logic [31:0] vb   [6] = '{32'h0, 32'h0, 32'hFFFF_FFE2, 32'h1, 32'h0, 32'h4};
        logic [4:0]  vs   [6] = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0};
        logic [31:0] vr   [6] = '{32'h8000_0000, 32'h8000_0000, 32'hC, 32'h3800_0007, 32'hF000_0001, 32'h0800_0000};
        int          vn   [6] = '{31, 0, 2, 1, 3, 4};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(code[i], va[i], vb[i], vs[i], lat);
            n_cmp++;
            if (lat !== exp_lat(vn[i]) || bus.result !== vr[i] || bus.carry_flag !== 1'b1 ||
                bus.zero_flag !== (vr[i] == 32'h0) || bus.sign_flag !== vr[i][31]) begin
                n_err++;
                $display("FAIL shift_%0d got lat=%0d r=%h c=%b z=%b s=%b exp lat=%0d r=%h c=1", i, lat,
                         bus.result, bus.carry_flag, bus.zero_flag, bus.sign_flag, exp_lat(vn[i]), vr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int extra;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control_signal = 4'b1110; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd20; bus.shamt = 5'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        extra = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) extra++;
        end
`ifndef FAST_SHIFT_EN
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL midrst_early_valid got %0d exp 0", extra); end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.err !== 1'b0) begin n_err++; $display("FAIL midrst_outputs got v=%b r=%h e=%b exp 0 0 0", bus.out_valid, bus.result, bus.err); end
        n_cmp++; if ({bus.carry_flag, bus.zero_flag, bus.sign_flag} !== 3'b000 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle got flags=%b rdy=%b exp 000 1", {bus.carry_flag, bus.zero_flag, bus.sign_flag}, bus.in_ready); end
        rst_n = 1'b1;
        extra = 0;
        for (int k = 1; k <= 24; k++) begin @(negedge clk); if (bus.out_valid === 1'b1) extra++; end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL midrst_late_valid got %0d exp 0", extra); end
        run_op(4'b0000, 32'h2, 32'h3, 5'd0, lat);
        n_cmp++; if (lat !== 1 || bus.result !== 32'h5 || bus.carry_flag !== 1'b0) begin n_err++; $display("FAIL midrst_recover got lat=%0d r=%h c=%b exp 1 5 0", lat, bus.result, bus.carry_flag); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_shra_midpulse();
        test_xor_carry_hold();
        test_arith();
        test_bad_code();
        test_shifts();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
